freeze_arbiter: RTL and testbench

FREEZE_ARBITER -- requirements
Module: freeze_arbiter

---
 rtl/freeze_pkg.sv | 13 +
 rtl/freeze_arbiter_if.sv | 39 +++
 rtl/freeze_arbiter_rr.sv | 26 ++
 rtl/freeze_arbiter.sv | 136 +++++++++++++
 tb/tb_freeze_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/freeze_pkg.sv
// Shared types and default timing constants for the camera freeze arbiter.
package freeze_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_FREEZE = 2'd2
   } state_e;

   localparam int DEF_FREEZE_FRAMES = 230;
   localparam int DEF_V_ACTIVE      = 480;

endpackage

// File: rtl/freeze_arbiter_if.sv
// Video-line, request and freeze-status bundle between a controller and the arbiter.
// The abort line exists only when FREEZE_ABORT_EN is defined.
interface freeze_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [9:0]         y_pixel;
   logic [NUM_REQ-1:0] req;
`ifdef FREEZE_ABORT_EN
   logic               abort;
`endif
   logic [NUM_REQ-1:0] grant;
   logic               freeze_val;
   logic [8:0]         frame_cnt;
   logic [NUM_REQ-1:0] pending;

   modport master (
      output y_pixel,
      output req,
`ifdef FREEZE_ABORT_EN
      output abort,
`endif
      input  grant,
      input  freeze_val,
      input  frame_cnt,
      input  pending
   );

   modport slave (
      input  y_pixel,
      input  req,
`ifdef FREEZE_ABORT_EN
      input  abort,
`endif
      output grant,
      output freeze_val,
      output frame_cnt,
      output pending
   );
endinterface

// File: rtl/freeze_arbiter_rr.sv
// Round-robin picker: first set pending bit at or after ptr_i, wrapping around.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] pending_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] winner_o,
   output logic               valid_o
);

   int idx;

   // Scan from the pointer; the first hit locks out every later candidate.
   always_comb begin
      winner_o = '0;
      valid_o  = 1'b0;
      idx      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx           = (int'(ptr_i) + k) % NUM_REQ;
         winner_o[idx] = winner_o[idx] | (pending_i[idx] & ~valid_o);
         valid_o       = valid_o | pending_i[idx];
      end
   end

endmodule

// File: rtl/freeze_arbiter.sv
// Grants one camera at a time a freeze of FREEZE_FRAMES whole frames, aligned to start-of-frame.
// Define FREEZE_ABORT_EN to add an abort input that ends an armed or running freeze.
module freeze_arbiter
   import freeze_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int FREEZE_FRAMES = DEF_FREEZE_FRAMES,
   parameter int V_ACTIVE      = DEF_V_ACTIVE
) (
   input logic              vga_pclk,
   input logic              reset_n,
   freeze_arbiter_if.slave  bus
);

   localparam int         PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
   localparam logic [8:0] LAST_CNT = 9'(FREEZE_FRAMES - 1);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] pending_q, pending_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [8:0]         frame_cnt_q, frame_cnt_d;
   logic               freeze_val_q, freeze_val_d;
   logic               prev_active_q;
   logic               active_s;
   logic               sof_s;
   logic [NUM_REQ-1:0] winner_s;
   logic               win_valid_s;

   assign active_s = (bus.y_pixel < V_ACT_L);
   assign sof_s    = active_s & ~prev_active_q;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .pending_i (pending_q),
      .ptr_i     (ptr_q),
      .winner_o  (winner_s),
      .valid_o   (win_valid_s)
   );

   // Next-state, grant, frame counter, pending set/clear and pointer update.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      frame_cnt_d  = frame_cnt_q;
      freeze_val_d = freeze_val_q;
      ptr_d        = ptr_q;
      pending_d    = pending_q | (bus.req & ~grant_q);
      case (state_q)
         ST_IDLE: begin
            if (win_valid_s) begin
               state_d   = ST_ARM;
               grant_d   = winner_s;
               pending_d = pending_d & ~winner_s;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (winner_s[i]) begin
                     ptr_d = PTR_W'((i + 1) % NUM_REQ);
                  end else begin
                     ptr_d = ptr_d;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ARM: begin
            if (sof_s) begin
               state_d      = ST_FREEZE;
               freeze_val_d = 1'b1;
               frame_cnt_d  = 9'd0;
            end else begin
               state_d = ST_ARM;
            end
         end
         ST_FREEZE: begin
            if (sof_s && (frame_cnt_q == LAST_CNT)) begin
               state_d      = ST_IDLE;
               grant_d      = '0;
               freeze_val_d = 1'b0;
               frame_cnt_d  = 9'd0;
            end else if (sof_s) begin
               frame_cnt_d = frame_cnt_q + 9'd1;
            end else begin
               state_d = ST_FREEZE;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            grant_d      = '0;
            freeze_val_d = 1'b0;
            frame_cnt_d  = 9'd0;
         end
      endcase
`ifdef FREEZE_ABORT_EN
      // Abort overrides any sof-driven transition but leaves pending and the pointer alone.
      if (bus.abort && (state_q != ST_IDLE)) begin
         state_d      = ST_IDLE;
         grant_d      = '0;
         freeze_val_d = 1'b0;
         frame_cnt_d  = 9'd0;
      end else begin
         state_d = state_d;
      end
`endif
   end

   // State and output registers; previous-active resets high so no sof fires straight out of reset.
   always_ff @(posedge vga_pclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         grant_q       <= '0;
         pending_q     <= '0;
         ptr_q         <= '0;
         frame_cnt_q   <= 9'd0;
         freeze_val_q  <= 1'b0;
         prev_active_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         pending_q     <= pending_d;
         ptr_q         <= ptr_d;
         frame_cnt_q   <= frame_cnt_d;
         freeze_val_q  <= freeze_val_d;
         prev_active_q <= active_s;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.pending    = pending_q;
   assign bus.frame_cnt  = frame_cnt_q;
   assign bus.freeze_val = freeze_val_q;

endmodule

// File: tb/tb_freeze_arbiter.sv
// Directed bench for freeze_arbiter with FREEZE_FRAMES=3 and hand-computed expectations.
module tb_freeze_arbiter;

   logic clk;
   logic reset_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   freeze_arbiter_if #(.NUM_REQ(4)) bus ();

   freeze_arbiter #(
      .NUM_REQ       (4),
      .FREEZE_FRAMES (3),
      .V_ACTIVE      (480)
   ) dut (
      .vga_pclk (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Blanking for a few lines then one active line, so exactly one sof is seen.
   task automatic frame();
      bus.y_pixel = 10'd600;
      repeat (3) tick();
      bus.y_pixel = 10'd0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      bus.y_pixel = 10'd600;
      bus.req     = 4'd0;
`ifdef FREEZE_ABORT_EN
      bus.abort   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_grant", bus.grant, 4'b0000);
      check_eq("rst_freeze", bus.freeze_val, 1'b0);
      check_eq("rst_cnt", bus.frame_cnt, 9'd0);
      check_eq("rst_pending", bus.pending, 4'b0000);
      reset_n = 1'b1;
      tick();

      // Simultaneous requests 0 and 2: 0 wins from a reset pointer.
      bus.req = 4'b0101;
      tick();
      bus.req = 4'b0000;
      check_eq("dual_pending", bus.pending, 4'b0101);
      check_eq("dual_grant_pre", bus.grant, 4'b0000);
      tick();
      check_eq("dual_grant0", bus.grant, 4'b0001);
      check_eq("dual_pending_left", bus.pending, 4'b0100);

      // Blanking only: ARM holds, no freeze.
      repeat (20) tick();
      check_eq("blank_freeze", bus.freeze_val, 1'b0);
      check_eq("blank_grant", bus.grant, 4'b0001);

      // First sof starts the freeze one cycle later.
      bus.y_pixel = 10'd0;
      tick();
      check_eq("frz_start", bus.freeze_val, 1'b1);
      check_eq("frz_cnt0", bus.frame_cnt, 9'd0);
      bus.y_pixel = 10'd100;
      tick();

      // Grantee re-request is dropped.
      bus.req = 4'b0001;
      tick();
      bus.req = 4'b0000;
      check_eq("self_req_dropped", bus.pending, 4'b0100);
      frame();
      check_eq("frz_cnt1", bus.frame_cnt, 9'd1);
      check_eq("frz_hold1", bus.freeze_val, 1'b1);
      frame();
      check_eq("frz_cnt2", bus.frame_cnt, 9'd2);
      check_eq("frz_hold2", bus.freeze_val, 1'b1);
      check_eq("pending_meanwhile", bus.pending, 4'b0100);
      frame();
      check_eq("frz_end", bus.freeze_val, 1'b0);
      check_eq("frz_end_grant", bus.grant, 4'b0000);
      check_eq("frz_end_cnt", bus.frame_cnt, 9'd0);

      // Requester 2 is served only after freeze 1 ended.
      tick();
      check_eq("second_grant", bus.grant, 4'b0100);
      check_eq("second_pending", bus.pending, 4'b0000);
      frame();
      check_eq("second_frz", bus.freeze_val, 1'b1);
      frame();
      frame();
      frame();
      check_eq("second_end", bus.freeze_val, 1'b0);
      repeat (10) tick();
      check_eq("no_refreeze_grant", bus.grant, 4'b0000);
      check_eq("no_refreeze_frz", bus.freeze_val, 1'b0);

      // Reset in the second frozen frame.
      bus.req = 4'b0010;
      tick();
      bus.req = 4'b0000;
      tick();
      check_eq("rst_case_grant", bus.grant, 4'b0010);
      frame();
      check_eq("rst_case_frz", bus.freeze_val, 1'b1);
      frame();
      check_eq("rst_case_cnt1", bus.frame_cnt, 9'd1);
      bus.y_pixel = 10'd100;
      bus.req     = 4'b1000;
      tick();
      bus.req = 4'b0000;
      check_eq("rst_case_pending", bus.pending, 4'b1000);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("async_rst_frz", bus.freeze_val, 1'b0);
      check_eq("async_rst_pending", bus.pending, 4'b0000);
      check_eq("async_rst_grant", bus.grant, 4'b0000);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      check_eq("no_sof_after_rst", dut.sof_s, 1'b0);
      bus.req = 4'b0001;
      tick();
      bus.req = 4'b0000;
      tick();
      check_eq("post_rst_grant", bus.grant, 4'b0001);
      repeat (10) tick();
      check_eq("post_rst_no_frz", bus.freeze_val, 1'b0);

`ifdef FREEZE_ABORT_EN
      // Abort coincident with sof wins over the counter increment.
      frame();
      check_eq("abort_frz_on", bus.freeze_val, 1'b1);
      bus.y_pixel = 10'd600;
      repeat (2) tick();
      bus.y_pixel = 10'd0;
      bus.abort   = 1'b1;
      tick();
      bus.abort = 1'b0;
      check_eq("abort_frz_off", bus.freeze_val, 1'b0);
      check_eq("abort_cnt", bus.frame_cnt, 9'd0);
      check_eq("abort_grant", bus.grant, 4'b0000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
